// File: rtl/scene_mux_pkg.sv
// Shared types for the scene multiplexer: FSM states, VGA field widths and the
// stage payload carried through the two-stage pipeline.
package scene_mux_pkg;

    localparam int unsigned VGA_CNT_W = 12;
    localparam int unsigned VGA_RGB_W = 12;

    typedef enum logic [1:0] {
        MUX_IDLE,
        MUX_FADE_OUT,
        MUX_FADE_IN,
        MUX_CUT
    } mux_state_t;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcount;
        logic [VGA_CNT_W-1:0] vcount;
        logic                 hsync;
        logic                 vsync;
        logic                 hblnk;
        logic                 vblnk;
        logic [VGA_RGB_W-1:0] rgb;
    } vga_bus_t;

endpackage

// File: rtl/scene_mux_rgb_dimmer.sv
// Combinational 4:4:4 brightness scaler: each channel becomes (c * level) >> FADE_SHIFT.
module scene_mux_rgb_dimmer
    import scene_mux_pkg::*;
#(
    parameter int unsigned FADE_SHIFT = 3
) (
    input  logic [VGA_RGB_W-1:0] rgb_i,
    input  logic [FADE_SHIFT:0]  level_i,
    output logic [VGA_RGB_W-1:0] rgb_c
);

    localparam int unsigned PROD_W = 4 + FADE_SHIFT + 1;

    logic [2:0][PROD_W-1:0] prod;

    // level never exceeds 2**FADE_SHIFT, so the shifted product always fits in 4 bits
    always_comb begin
        prod  = '0;
        rgb_c = '0;
        for (int ch = 0; ch < 3; ch++) begin
            prod[ch]         = PROD_W'(rgb_i[ch*4 +: 4]) * PROD_W'(level_i);
            rgb_c[ch*4 +: 4] = 4'(prod[ch] >> FADE_SHIFT);
        end
    end

endmodule

// File: rtl/scene_mux.sv
// N-input VGA scene selector: switches scenes only inside vertical blanking,
// with an optional frame-stepped fade to black and back.
module scene_mux
    import scene_mux_pkg::*;
#(
    parameter int unsigned NUM_SCENES = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_SCENES),
    parameter int unsigned FADE_SHIFT = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [SEL_W-1:0]                      scene_sel,
    input  logic [NUM_SCENES-1:0][VGA_CNT_W-1:0]  in_hcount,
    input  logic [NUM_SCENES-1:0][VGA_CNT_W-1:0]  in_vcount,
    input  logic [NUM_SCENES-1:0]                 in_hsync,
    input  logic [NUM_SCENES-1:0]                 in_vsync,
    input  logic [NUM_SCENES-1:0]                 in_hblnk,
    input  logic [NUM_SCENES-1:0]                 in_vblnk,
    input  logic [NUM_SCENES-1:0][VGA_RGB_W-1:0]  in_rgb,
    output vga_bus_t                              vga_out,
    output logic [SEL_W-1:0]                      active_scene,
    output logic                                  busy
);

    localparam int unsigned      LVL_W    = FADE_SHIFT + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(1 << FADE_SHIFT);

    mux_state_t       state_q, state_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             busy_q, busy_d;
    logic             vblnk_prev_q, vblnk_prev_d;
    vga_bus_t         s1_q, s1_d;
    vga_bus_t         s2_q, s2_d;

    logic [SEL_W-1:0]     sel_eff_c;
    logic                 frame_edge_c;
    logic [VGA_RGB_W-1:0] dim_rgb_c;

    scene_mux_rgb_dimmer #(
        .FADE_SHIFT (FADE_SHIFT)
    ) u_dimmer (
        .rgb_i   (s1_q.rgb),
        .level_i (level_q),
        .rgb_c   (dim_rgb_c)
    );

    // Out-of-range requests fall back to scene 0
    always_comb begin
        sel_eff_c = '0;
        if ({1'b0, scene_sel} < (SEL_W+1)'(NUM_SCENES)) begin
            sel_eff_c = scene_sel;
        end
        frame_edge_c = s1_q.vblnk & ~vblnk_prev_q;
    end

    // Stage 1 mux, stage 2 blanking and dimming
    always_comb begin
        s1_d = '0;
        for (int i = 0; i < int'(NUM_SCENES); i++) begin
            if (active_q == SEL_W'(i)) begin
                s1_d.hcount = in_hcount[i];
                s1_d.vcount = in_vcount[i];
                s1_d.hsync  = in_hsync[i];
                s1_d.vsync  = in_vsync[i];
                s1_d.hblnk  = in_hblnk[i];
                s1_d.vblnk  = in_vblnk[i];
                s1_d.rgb    = in_rgb[i];
            end
        end
        vblnk_prev_d = s1_q.vblnk;
        s2_d         = s1_q;
        s2_d.rgb     = (s1_q.hblnk | s1_q.vblnk) ? '0 : dim_rgb_c;
    end

    // Transition FSM; active scene and level only move on frame edges
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        active_d = active_q;
        level_d  = level_q;
        case (state_q)
            MUX_IDLE: begin
                if (sel_eff_c != active_q) begin
                    target_d = sel_eff_c;
                    state_d  = (FADE_SHIFT == 0) ? MUX_CUT : MUX_FADE_OUT;
                end
            end
            MUX_FADE_OUT: begin
                target_d = sel_eff_c;
                if (frame_edge_c) begin
                    level_d = level_q - LVL_W'(1);
                    if (level_q == LVL_W'(1)) begin
                        active_d = target_q;
                        state_d  = MUX_FADE_IN;
                    end
                end else if (sel_eff_c == active_q) begin
                    state_d = MUX_FADE_IN;
                end
            end
            MUX_FADE_IN: begin
                if (level_q == LVL_FULL) begin
                    state_d = MUX_IDLE;
                end else if (frame_edge_c) begin
                    level_d = level_q + LVL_W'(1);
                    if (level_d == LVL_FULL) begin
                        state_d = MUX_IDLE;
                    end
                end
            end
            MUX_CUT: begin
                if (frame_edge_c) begin
                    active_d = target_q;
                    state_d  = MUX_IDLE;
                end
            end
            default: state_d = MUX_IDLE;
        endcase
        busy_d = (state_d != MUX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MUX_IDLE;
            target_q     <= '0;
            active_q     <= '0;
            level_q      <= LVL_FULL;
            busy_q       <= 1'b0;
            vblnk_prev_q <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            active_q     <= active_d;
            level_q      <= level_d;
            busy_q       <= busy_d;
            vblnk_prev_q <= vblnk_prev_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
        end
    end

    assign vga_out      = s2_q;
    assign active_scene = active_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_scene_mux.sv
// Directed bench for scene_mux: a fading instance (FADE_SHIFT=3) and a hard-cut
// instance (FADE_SHIFT=0, 3-bit select) share a tiny 16x8 raster.
module tb_scene_mux;
    import scene_mux_pkg::*;

    localparam logic [11:0] RGB0  = 12'hFA5;
    localparam logic [11:0] RGB1  = 12'h5C3;
    localparam logic [11:0] RGB2  = 12'h3F8;
    localparam logic [11:0] RGB3  = 12'hA6C;
    localparam int          LIMIT = 300;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic [3:0][11:0] in_hcount, in_vcount, in_rgb;
    logic [3:0] in_hsync, in_vsync, in_hblnk, in_vblnk;
    vga_bus_t out_a, out_b;
    logic [1:0] act_a;
    logic [2:0] act_b;
    logic busy_a, busy_b;

    int hc, vc;
    int checks = 0;
    int errors = 0;
    int exp_red [7];

    always #5 clk = ~clk;

    scene_mux #(.NUM_SCENES(4), .SEL_W(2), .FADE_SHIFT(3)) dut_a (
        .clk(clk), .rst(rst), .scene_sel(sel_a),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
        .vga_out(out_a), .active_scene(act_a), .busy(busy_a)
    );

    scene_mux #(.NUM_SCENES(4), .SEL_W(3), .FADE_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .scene_sel(sel_b),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
        .vga_out(out_b), .active_scene(act_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_hcount[i] = 12'(hc);
            in_vcount[i] = 12'(vc);
            in_hsync[i]  = (hc == 12);
            in_vsync[i]  = (vc == 6);
            in_hblnk[i]  = (hc >= 10);
            in_vblnk[i]  = (vc >= 5);
        end
        in_rgb = {RGB3, RGB2, RGB1, RGB0};
    endtask

    // One clock: sample point is #1 after the edge, then the raster advances
    task automatic cyc();
        @(posedge clk);
        #1;
        hc++;
        if (hc == 16) begin
            hc = 0;
            vc++;
            if (vc == 8) vc = 0;
        end
        drive();
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!(hc == h && vc == v) && n < LIMIT);
        if (!(hc == h && vc == v)) begin
            checks++;
            errors++;
            $error("FAIL timeout: waited %0d cycles for pixel %0d,%0d", n, h, v);
        end
    endtask

    // Output shows pixel (h,v) two clocks after it is driven
    task automatic wait_pixel(input int h, input int v);
        wait_pos(h, v);
        cyc();
        cyc();
    endtask

    // Stops in the cycle where the internal frame edge pulse is high
    task automatic to_pulse();
        wait_pos(0, 5);
        cyc();
    endtask

    task automatic frame_step();
        to_pulse();
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_red = '{13, 11, 9, 7, 5, 3, 1};
        rst = 1'b1; sel_a = 2'd0; sel_b = 3'd0;
        hc = 0; vc = 0;
        drive();
        repeat (3) cyc();

        chk("reset_out_a", 64'(out_a), 64'd0);
        chk("reset_out_b", 64'(out_b), 64'd0);
        chk("reset_act_a", 64'(act_a), 64'd0);
        chk("reset_busy_a", 64'(busy_a), 64'd0);
        chk("reset_busy_b", 64'(busy_b), 64'd0);
        rst = 1'b0;

        wait_pixel(0, 0);
        chk("pass_rgb", 64'(out_a.rgb), 64'(RGB0));
        chk("pass_busy", 64'(busy_a), 64'd0);
        wait_pixel(3, 2);
        chk("lat_hcount", 64'(out_a.hcount), 64'd3);
        chk("lat_vcount", 64'(out_a.vcount), 64'd2);

        // Hard cut on the FADE_SHIFT=0 instance
        sel_b = 3'd3;
        cyc();
        chk("cut_busy_rise", 64'(busy_b), 64'd1);
        chk("cut_act_hold", 64'(act_b), 64'd0);
        to_pulse();
        chk("cut_act_pre_edge", 64'(act_b), 64'd0);
        cyc();
        chk("cut_act_switch", 64'(act_b), 64'd3);
        chk("cut_busy_fall", 64'(busy_b), 64'd0);
        chk("cut_in_vblank", 64'(out_b.vblnk), 64'd1);
        chk("cut_blank_rgb", 64'(out_b.rgb), 64'd0);
        wait_pixel(0, 0);
        chk("cut_rgb_s3", 64'(out_b.rgb), 64'(RGB3));
        sel_b = 3'd7;
        cyc();
        chk("cut_sel7_busy", 64'(busy_b), 64'd1);
        frame_step();
        chk("cut_sel7_act", 64'(act_b), 64'd0);
        wait_pixel(0, 0);
        chk("cut_sel7_rgb", 64'(out_b.rgb), 64'(RGB0));
        chk("idle_a_busy", 64'(busy_a), 64'd0);

        // Fade 0 -> 2, requested mid-frame
        sel_a = 2'd2;
        cyc();
        chk("fade_busy_rise", 64'(busy_a), 64'd1);
        for (int n = 1; n <= 7; n++) begin
            frame_step();
            wait_pixel(0, 0);
            chk($sformatf("fade_red_e%0d", n), 64'(out_a.rgb[11:8]), 64'(exp_red[n-1]));
            chk($sformatf("fade_act_e%0d", n), 64'(act_a), 64'd0);
        end
        to_pulse();
        chk("fade_act_pre_e8", 64'(act_a), 64'd0);
        cyc();
        chk("fade_act_e8", 64'(act_a), 64'd2);
        chk("fade_vblank_e8", 64'(out_a.vblnk), 64'd1);
        wait_pixel(0, 0);
        chk("fade_black_e8", 64'(out_a.rgb), 64'd0);
        for (int n = 9; n <= 16; n++) begin
            frame_step();
            if (n == 9) begin
                wait_pixel(0, 0);
                chk("fade_rgb_e9", 64'(out_a.rgb), 64'h011);
            end
            if (n == 12) begin
                wait_pixel(0, 0);
                chk("fade_rgb_e12", 64'(out_a.rgb), 64'h174);
                wait_pixel(11, 0);
                chk("fade_hblnk_flag", 64'(out_a.hblnk), 64'd1);
                chk("fade_hblnk_rgb", 64'(out_a.rgb), 64'd0);
            end
            if (n == 15) chk("fade_busy_e15", 64'(busy_a), 64'd1);
        end
        chk("fade_busy_e16", 64'(busy_a), 64'd0);
        wait_pixel(0, 0);
        chk("fade_rgb_full", 64'(out_a.rgb), 64'(RGB2));

        // Retarget 2 -> 1 -> 3 after fade-out edge 4
        sel_a = 2'd1;
        for (int n = 1; n <= 16; n++) begin
            frame_step();
            if (n == 4) sel_a = 2'd3;
            chk($sformatf("retarget_act_e%0d", n), 64'(act_a), (n < 8) ? 64'd2 : 64'd3);
        end
        chk("retarget_busy", 64'(busy_a), 64'd0);

        // Abort 3 -> 0 -> back to 3 after edge 3
        sel_a = 2'd0;
        cyc();
        chk("abort_busy_rise", 64'(busy_a), 64'd1);
        repeat (3) frame_step();
        chk("abort_act_e3", 64'(act_a), 64'd3);
        sel_a = 2'd3;
        cyc();
        frame_step();
        wait_pixel(0, 0);
        chk("abort_rgb_l6", 64'(out_a.rgb), 64'h749);
        chk("abort_act_e4", 64'(act_a), 64'd3);
        frame_step();
        chk("abort_busy_e5", 64'(busy_a), 64'd1);
        frame_step();
        chk("abort_busy_e6", 64'(busy_a), 64'd0);
        chk("abort_act_e6", 64'(act_a), 64'd3);
        wait_pixel(0, 0);
        chk("abort_rgb_full", 64'(out_a.rgb), 64'(RGB3));

        // Select changes during the switching frame-edge cycle
        sel_a = 2'd1;
        repeat (7) frame_step();
        to_pulse();
        sel_a = 2'd2;
        cyc();
        chk("bound_act_e8", 64'(act_a), 64'd1);
        repeat (8) frame_step();
        chk("bound_busy_e16", 64'(busy_a), 64'd0);
        chk("bound_act_e16", 64'(act_a), 64'd1);
        cyc();
        chk("bound_pending", 64'(busy_a), 64'd1);

        // Reset in the middle of the pending 1 -> 2 fade, at level 4
        repeat (4) frame_step();
        wait_pixel(0, 0);
        chk("rstmid_rgb_l4", 64'(out_a.rgb), 64'h261);
        rst = 1'b1;
        sel_a = 2'd0;
        cyc();
        chk("rstmid_act", 64'(act_a), 64'd0);
        chk("rstmid_busy", 64'(busy_a), 64'd0);
        chk("rstmid_out", 64'(out_a), 64'd0);
        rst = 1'b0;
        wait_pixel(0, 0);
        chk("rstmid_rgb_full", 64'(out_a.rgb), 64'(RGB0));
        chk("rstmid_busy_after", 64'(busy_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
